io_scan_ctrl: RTL and testbench
===============================

IO_SCAN_CTRL -- requirements
Module: io_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 16, scan counter width; one digit slot lasts 2^(SCAN_BITS-2) cycles.
REQ-002 SHALL have parameter BLANK_CYCLES, default 64, blanking cycles at the start of each digit slot.
REQ-003 SHALL have parameter DEB_MAX, default 50000, debounce stability count (5 ms at 10 MHz).
REQ-004 SHALL have port CLK, input, 1, system clock; all state changes on posedge CLK.
REQ-005 SHALL have port RESET, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port IOAddr, input, 4, processor IO address.
REQ-007 SHALL have port IOWriteEn, input, 1, IO write strobe; one write per cycle high.
REQ-008 SHALL have port IOWriteData, input, 32, IO write data.
REQ-009 SHALL have port IOReadData, output, 32, combinational read data for IOAddr.
REQ-010 SHALL have port SW, input, 2, raw asynchronous switch inputs (speed select).
REQ-011 SHALL have port LED, output, 7, registered segment drive, active-low.
REQ-012 SHALL have port AN, output, 4, registered digit anode drive, active-low.

Function
REQ-013 Writes at IOAddr 4'h0 SHALL load disp_reg[27:0] <= IOWriteData[27:0]; digit n uses disp_reg[7n+6:7n], bit=1 means segment lit.
REQ-014 Writes at 4'h1 SHALL load digit mask[3:0] <= IOWriteData[3:0]; mask bit 0 forces that digit's anode off.
REQ-015 Writes at 4'h2 SHALL load period[23:0] <= IOWriteData[23:0] and clear tick counter to 0 in the same cycle.
REQ-016 Writes at 4'h5 SHALL clear tick_flag; writes to any other address SHALL be ignored.
REQ-017 Reads: 4'h4 -> {30'b0, sw_stable}; 4'h5 -> {31'b0, tick_flag}; 4'h6 -> {16'b0, tick_cnt}; 4'h1 -> {28'b0, mask}; 4'h2 -> {8'b0, period}; all other addresses -> 32'b0.
REQ-018 SW SHALL pass a 2-flop synchronizer per bit before debouncing.
REQ-019 Debouncer: if synced == sw_stable, deb_cnt <= 0; else deb_cnt increments; when deb_cnt == DEB_MAX-1, sw_stable <= synced and deb_cnt <= 0.
REQ-020 A bounce (synced returns to sw_stable) before DEB_MAX SHALL restart the count; sw_stable changes only after DEB_MAX consecutive differing cycles.
REQ-021 Scan counter SHALL be SCAN_BITS wide, free-running, wrapping to 0; digit index = scan[SCAN_BITS-1:SCAN_BITS-2].
REQ-022 Scan FSM states DIG0->DIG1->DIG2->DIG3->DIG0, advancing when the low SCAN_BITS-2 bits wrap.
REQ-023 During slot offset < BLANK_CYCLES, AN SHALL be 4'hF and LED 7'h7F (blank).
REQ-024 Otherwise AN SHALL drive only the current digit low (DIG0 -> 4'b1110 ... DIG3 -> 4'b0111) if its mask bit is 1, else 4'hF; LED SHALL be ~segments of current digit (7'h7F if masked).
REQ-025 AN/LED SHALL be registered: output reflects scan state of the previous cycle (1-cycle latency).
REQ-026 disp_reg/mask writes SHALL take effect on LED from the next scan-driven output update; no tearing within a cycle.
REQ-027 Tick timer: when period != 0, tick counter increments each cycle; at count == period-1 it wraps to 0, sets tick_flag, tick_cnt increments (16-bit, wraps 16'hFFFF->0).
REQ-028 period == 0 SHALL halt the timer with counter held at 0; no ticks generated.
REQ-029 Simultaneous tick set and clear-write (4'h5) SHALL leave tick_flag = 1 (set wins).
REQ-030 A period write coinciding with a terminal count SHALL suppress that tick; counter restarts at 0.

Reset
REQ-031 RESET SHALL asynchronously set: disp_reg=0, mask=4'hF, period=0, timer counter=0, tick_flag=0, tick_cnt=0, scan=0 (DIG0), synchronizer flops=0, sw_stable=0, deb_cnt=0, AN=4'hF, LED=7'h7F.
REQ-032 Reset asserted mid-operation SHALL return all state to REQ-031 values immediately; operation resumes at DIG0 first cycle after deassertion.

Verification
REQ-033 Write 4'h0 = 28'h0000006, run one full scan (SCAN_BITS=6, BLANK_CYCLES=2) -> AN cycles 1110/1101/1011/0111 with blank 4'hF first 2 cycles of each slot; LED=7'h79 during DIG0, 7'h7F elsewhere.
REQ-034 Write mask = 4'b0101 -> AN never drives 1101 or 0111; those slots show AN=4'hF.
REQ-035 DEB_MAX=8: SW 00->01 held 3 cycles, back to 00, then 01 held 20 cycles -> read 4'h4 stays 0 through bounce, becomes 1 exactly 2+8 cycles after final edge (+/-1 for sync phase).
REQ-036 Write period=5 -> tick_flag sets every 5 cycles, read 4'h6 counts 1,2,3...; write 4'h5 on a tick cycle -> flag stays 1; write 4'h5 later -> flag 0.
REQ-037 Write period=0 mid-count -> no further ticks, tick_cnt frozen; tick_cnt preset via 65536 ticks wraps to 0.
REQ-038 Assert RESET mid-scan with nonzero state -> all outputs/reads match REQ-031 in same cycle; read 4'h1 returns 4'hF.

Source files
------------

// File: rtl/io_scan_ctrl.sv
// Memory-mapped 4-digit seven-segment scanner with a debounced 2-bit switch input
// and a programmable tick timer.
module io_scan_ctrl #(
  parameter int unsigned SCAN_BITS    = 16,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned DEB_MAX      = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  IOAddr,
  input  logic        IOWriteEn,
  input  logic [31:0] IOWriteData,
  output logic [31:0] IOReadData,
  input  logic [1:0]  SW,
  output logic [6:0]  LED,
  output logic [3:0]  AN
);

  localparam int unsigned SlotW = SCAN_BITS - 2;
  localparam int unsigned DebW  = $clog2(DEB_MAX + 1);

  typedef enum logic [1:0] {StDig0, StDig1, StDig2, StDig3} dig_e;

  logic [27:0]          disp_q;
  logic [3:0]           mask_q;
  logic [23:0]          period_q;
  logic [23:0]          tmr_q, tmr_d;
  logic                 tick_flag_q, tick_flag_d;
  logic [15:0]          tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [SCAN_BITS-1:0] scan_q;
  dig_e                 state_q, state_d;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           sw_stable_q, sw_stable_d;
  logic [DebW-1:0]      deb_cnt_q, deb_cnt_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           led_q, led_d;

  logic wr_disp, wr_mask, wr_period, wr_clr;
  assign wr_disp   = IOWriteEn && (IOAddr == 4'h0);
  assign wr_mask   = IOWriteEn && (IOAddr == 4'h1);
  assign wr_period = IOWriteEn && (IOAddr == 4'h2);
  assign wr_clr    = IOWriteEn && (IOAddr == 4'h5);

  // Tick timer; a period write restarts the count and swallows any coincident tick.
  always_comb begin
    tmr_d = tmr_q;
    tick  = 1'b0;
    if (wr_period || (period_q == 24'd0)) begin
      tmr_d = 24'd0;
    end else if (tmr_q == period_q - 24'd1) begin
      tmr_d = 24'd0;
      tick  = 1'b1;
    end else begin
      tmr_d = tmr_q + 24'd1;
    end
    tick_cnt_d  = tick ? tick_cnt_q + 16'd1 : tick_cnt_q;
    tick_flag_d = tick ? 1'b1 : (wr_clr ? 1'b0 : tick_flag_q);
  end

  always_comb begin
    deb_cnt_d   = '0;
    sw_stable_d = sw_stable_q;
    if (sync2_q != sw_stable_q) begin
      if (deb_cnt_q == DebW'(DEB_MAX - 1)) begin
        sw_stable_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  logic             slot_wrap, blank, mask_bit;
  logic [3:0]       an_sel;
  logic [6:0]       seg;
  assign slot_wrap = &scan_q[SlotW-1:0];
  assign blank     = 32'(scan_q[SlotW-1:0]) < BLANK_CYCLES;

  // The FSM state always equals the top two scan bits; it advances as the slot offset wraps.
  always_comb begin
    state_d  = state_q;
    an_sel   = 4'hF;
    seg      = 7'h00;
    mask_bit = 1'b0;
    unique case (state_q)
      StDig0: begin
        an_sel   = 4'b1110;
        seg      = disp_q[6:0];
        mask_bit = mask_q[0];
        if (slot_wrap) state_d = StDig1;
      end
      StDig1: begin
        an_sel   = 4'b1101;
        seg      = disp_q[13:7];
        mask_bit = mask_q[1];
        if (slot_wrap) state_d = StDig2;
      end
      StDig2: begin
        an_sel   = 4'b1011;
        seg      = disp_q[20:14];
        mask_bit = mask_q[2];
        if (slot_wrap) state_d = StDig3;
      end
      StDig3: begin
        an_sel   = 4'b0111;
        seg      = disp_q[27:21];
        mask_bit = mask_q[3];
        if (slot_wrap) state_d = StDig0;
      end
    endcase
    an_d  = 4'hF;
    led_d = 7'h7F;
    if (!blank && mask_bit) begin
      an_d  = an_sel;
      led_d = ~seg;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      disp_q      <= '0;
      mask_q      <= 4'hF;
      period_q    <= '0;
      tmr_q       <= '0;
      tick_flag_q <= 1'b0;
      tick_cnt_q  <= '0;
      scan_q      <= '0;
      state_q     <= StDig0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_stable_q <= '0;
      deb_cnt_q   <= '0;
      an_q        <= 4'hF;
      led_q       <= 7'h7F;
    end else begin
      if (wr_disp)   disp_q   <= IOWriteData[27:0];
      if (wr_mask)   mask_q   <= IOWriteData[3:0];
      if (wr_period) period_q <= IOWriteData[23:0];
      tmr_q       <= tmr_d;
      tick_flag_q <= tick_flag_d;
      tick_cnt_q  <= tick_cnt_d;
      scan_q      <= scan_q + SCAN_BITS'(1);
      state_q     <= state_d;
      sync1_q     <= SW;
      sync2_q     <= sync1_q;
      sw_stable_q <= sw_stable_d;
      deb_cnt_q   <= deb_cnt_d;
      an_q        <= an_d;
      led_q       <= led_d;
    end
  end

  assign AN  = an_q;
  assign LED = led_q;

  always_comb begin
    IOReadData = 32'd0;
    case (IOAddr)
      4'h1:    IOReadData = {28'd0, mask_q};
      4'h2:    IOReadData = {8'd0, period_q};
      4'h4:    IOReadData = {30'd0, sw_stable_q};
      4'h5:    IOReadData = {31'd0, tick_flag_q};
      4'h6:    IOReadData = {16'd0, tick_cnt_q};
      default: IOReadData = 32'd0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{IOWriteData[31:28], scan_q[SCAN_BITS-1 -: 2]};

endmodule

// File: tb/tb_io_scan_ctrl.sv
// Bench for io_scan_ctrl: cycle model of scan/timer/debounce plus directed literal checks.
module tb_io_scan_ctrl;

  localparam int SB    = 6;
  localparam int BC    = 2;
  localparam int DM    = 8;
  localparam int SLOT  = 16;
  localparam int NSCAN = 64;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  IOAddr;
  logic        IOWriteEn;
  logic [31:0] IOWriteData;
  logic [31:0] IOReadData;
  logic [1:0]  SW;
  logic [6:0]  LED;
  logic [3:0]  AN;

  io_scan_ctrl #(
    .SCAN_BITS   (SB),
    .BLANK_CYCLES(BC),
    .DEB_MAX     (DM)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOAddr     (IOAddr),
    .IOWriteEn  (IOWriteEn),
    .IOWriteData(IOWriteData),
    .IOReadData (IOReadData),
    .SW         (SW),
    .LED        (LED),
    .AN         (AN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: values the DUT registers must hold after each clock edge.
  int          m_scan;
  logic [27:0] m_disp;
  logic [3:0]  m_mask;
  logic [23:0] m_period;
  int          m_phase;
  logic        m_flag;
  logic [15:0] m_tcnt;
  logic [1:0]  m_s1, m_s2, m_stable;
  int          m_run;
  logic [3:0]  m_an;
  logic [6:0]  m_led;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h1:    return {28'd0, m_mask};
      4'h2:    return {8'd0, m_period};
      4'h4:    return {30'd0, m_stable};
      4'h5:    return {31'd0, m_flag};
      4'h6:    return {16'd0, m_tcnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int dig;
    int off;
    bit tick;
    dig = m_scan / SLOT;
    off = m_scan % SLOT;
    if (off < BC || !m_mask[dig]) begin
      m_an  = 4'hF;
      m_led = 7'h7F;
    end else begin
      m_an  = ~(4'b0001 << dig);
      m_led = ~m_disp[7*dig +: 7];
    end
    m_scan = (m_scan + 1) % NSCAN;
    tick = 1'b0;
    if (IOWriteEn && IOAddr == 4'h2) begin
      m_period = IOWriteData[23:0];
      m_phase  = 0;
    end else if (m_period != 24'd0) begin
      m_phase++;
      if (m_phase == int'(m_period)) begin
        m_phase = 0;
        tick    = 1'b1;
      end
    end
    if (tick) begin
      m_flag = 1'b1;
      m_tcnt++;
    end else if (IOWriteEn && IOAddr == 4'h5) begin
      m_flag = 1'b0;
    end
    if (IOWriteEn && IOAddr == 4'h0) m_disp = IOWriteData[27:0];
    if (IOWriteEn && IOAddr == 4'h1) m_mask = IOWriteData[3:0];
    // Stable value follows the synchronised input after DM consecutive differing cycles.
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DM) begin
        m_stable = m_s2;
        m_run    = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = SW;
  endtask

  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      m_scan = 0;  m_disp = '0;  m_mask = 4'hF; m_period = '0; m_phase = 0;
      m_flag = 0;  m_tcnt = '0;  m_s1 = '0;     m_s2 = '0;     m_stable = '0;
      m_run = 0;   m_an = 4'hF;  m_led = 7'h7F; m_valid = 1'b1;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(posedge CLK);
    #2;
    if (m_valid && !RESET) begin
      chk("an", {28'd0, AN}, {28'd0, m_an});
      chk("led", {25'd0, LED}, {25'd0, m_led});
      chk("rdata", IOReadData, m_read(IOAddr));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    IOAddr = a; IOWriteEn = 1'b1; IOWriteData = d;
    @(negedge CLK);
    IOWriteEn = 1'b0;
  endtask

  logic [3:0] an_log [0:66];
  logic [6:0] led_log[0:66];
  int bad, seen0;

  initial begin
    IOAddr = 4'h0; IOWriteEn = 1'b0; IOWriteData = '0; SW = 2'b00; RESET = 1'b1;
    repeat (2) @(negedge CLK);
    IOAddr = 4'h1;
    #1;
    chk("rst_mask", IOReadData, 32'hF);
    chk("rst_an", {28'd0, AN}, 32'hF);
    chk("rst_led", {25'd0, LED}, 32'h7F);

    // Scan: digit 0 shows segments b,c; edge k displays scan value k-1.
    @(negedge CLK);
    RESET = 1'b0; IOWriteEn = 1'b1; IOAddr = 4'h0; IOWriteData = 32'h6;
    for (int k = 1; k <= 66; k++) begin
      @(posedge CLK);
      #2;
      IOWriteEn   = 1'b0;
      an_log[k]   = AN;
      led_log[k]  = LED;
    end
    chk("scan_e1_blank", {28'd0, an_log[1]}, 32'hF);
    chk("scan_dig0_an", {28'd0, an_log[3]}, 32'hE);
    chk("scan_dig0_led", {25'd0, led_log[3]}, 32'h79);
    chk("scan_dig0_end", {28'd0, an_log[16]}, 32'hE);
    chk("scan_dig1_blank", {28'd0, an_log[17]}, 32'hF);
    chk("scan_dig1_an", {28'd0, an_log[19]}, 32'hD);
    chk("scan_dig1_led", {25'd0, led_log[19]}, 32'h7F);
    chk("scan_dig2_an", {28'd0, an_log[35]}, 32'hB);
    chk("scan_dig3_an", {28'd0, an_log[51]}, 32'h7);
    chk("scan_wrap_blank", {28'd0, an_log[65]}, 32'hF);

    wr(4'h1, 32'h5);
    bad = 0; seen0 = 0;
    repeat (NSCAN + 2) begin
      @(posedge CLK);
      #2;
      if (AN == 4'b1101 || AN == 4'b0111) bad++;
      if (AN == 4'b1110) seen0++;
    end
    chk("mask_forbidden", bad, 0);
    chk("mask_dig0_lit", {31'd0, seen0 > 0}, 32'd1);
    IOAddr = 4'h1;
    #1 chk("mask_read", IOReadData, 32'h5);

    wr(4'h3, 32'hFFFF_FFFF);
    IOAddr = 4'h2;
    #1 chk("ignored_write", IOReadData, 32'h0);

    // Debounce: a 3-cycle glitch, then a clean edge seen 2+DM edges later.
    IOAddr = 4'h4;
    @(negedge CLK) SW = 2'b01;
    repeat (3) @(negedge CLK);
    SW = 2'b00;
    repeat (6) @(negedge CLK);
    chk("deb_bounce", IOReadData, 32'h0);
    SW = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #2;
      if (k == 9)  chk("deb_edge9", IOReadData, 32'h0);
      if (k == 10) chk("deb_edge10", IOReadData, 32'h1);
    end

    // Tick timer with period 5.
    wr(4'h2, 32'd5);
    IOAddr = 4'h6;
    repeat (5) @(posedge CLK);
    #2 chk("tick_cnt1", IOReadData, 32'd1);
    repeat (5) @(posedge CLK);
    #2 chk("tick_cnt2", IOReadData, 32'd2);
    repeat (5) @(negedge CLK);
    IOWriteEn = 1'b1; IOAddr = 4'h5; IOWriteData = '0;
    @(posedge CLK);
    #2;
    IOWriteEn = 1'b0;
    chk("clr_on_tick_set_wins", IOReadData, 32'h1);
    IOAddr = 4'h6;
    #1 chk("tick_cnt3", IOReadData, 32'd3);
    @(negedge CLK);
    IOWriteEn = 1'b1; IOAddr = 4'h5;
    @(posedge CLK);
    #2;
    IOWriteEn = 1'b0;
    chk("clr_later", IOReadData, 32'h0);
    wr(4'h2, 32'd0);
    IOAddr = 4'h6;
    repeat (20) @(posedge CLK);
    #2 chk("tick_frozen", IOReadData, 32'd3);

    // Asynchronous reset mid-operation with nonzero state.
    wr(4'h2, 32'd7);
    repeat (3) @(negedge CLK);
    #1;
    RESET = 1'b1; IOAddr = 4'h1;
    #1;
    chk("mid_rst_mask", IOReadData, 32'hF);
    chk("mid_rst_an", {28'd0, AN}, 32'hF);
    chk("mid_rst_led", {25'd0, LED}, 32'h7F);
    IOAddr = 4'h6;
    #1 chk("mid_rst_tcnt", IOReadData, 32'h0);
    IOAddr = 4'h4;
    #1 chk("mid_rst_sw", IOReadData, 32'h0);
    IOAddr = 4'h2;
    #1 chk("mid_rst_period", IOReadData, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // 65536 ticks at period 1 wrap the tick counter back to zero.
    wr(4'h2, 32'd1);
    repeat (65536) @(negedge CLK);
    IOWriteEn = 1'b1; IOAddr = 4'h2; IOWriteData = 32'd0;
    @(negedge CLK);
    IOWriteEn = 1'b0; IOAddr = 4'h6;
    #1 chk("tick_wrap", IOReadData, 32'h0);
    IOAddr = 4'h5;
    #1 chk("tick_wrap_flag", IOReadData, 32'h1);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
